sd_data_fifo_bridge: RTL
========================

// Module: sd_data_fifo_bridge
// PURPOSE
//  Word buffer between the bus-side data port and the SD data serial host.
//  TX path: bus pushes 32-bit words; the serial host pops them via rd/data_in (first-word-fall-through).
//  RX path: the serial host pushes via we/data_out; the bus pops them.
//  Single clock domain (sd_clk); flush on transfer abort; level/flag reporting for the register block.
// PARAMETERS
//  DW        32  data word width
//  AW        4   log2(depth); each FIFO holds 2**AW words (16)
// PORTS
//  sd_clk        in   1      clock shared with the serial host
//  rst_n         in   1      reset, asynchronous assert, active-low
//  flush         in   1      sync clear of both FIFOs (driven on abort, start==2'b11)
//  tx_wr         in   1      bus push into TX FIFO
//  tx_wdata      in   DW     bus write word
//  tx_full       out  1      TX FIFO holds 2**AW words
//  tx_level      out  AW+1   TX occupancy
//  host_rd       in   1      serial host pop (its rd)
//  host_data_in  out  DW     TX head word (drives the host's data_in)
//  tx_empty      out  1      TX FIFO empty
//  host_we       in   1      serial host push (its we)
//  host_data_out in   DW     serial host received word (its data_out)
//  rx_rd         in   1      bus pop from RX FIFO
//  rx_rdata      out  DW     RX head word
//  rx_empty      out  1      RX FIFO empty
//  rx_full       out  1      RX FIFO full
//  rx_level      out  AW+1   RX occupancy
//  tx_underrun   out  1      sticky: host_rd while TX empty (macro-dependent)
//  rx_overflow   out  1      sticky: host_we while RX full (macro-dependent)
// BEHAVIOUR
//  Reset (rst_n=0, async): pointers/levels 0; tx_empty=rx_empty=1; tx_full=rx_full=0;
//   host_data_in=rx_rdata=0; tx_underrun=rx_overflow=0.
//  Storage: per FIFO, a 2**AW x DW array; wr_ptr/rd_ptr AW+1 bits. MSB differs and low bits equal -> full;
//   all bits equal -> empty; level = wr_ptr - rd_ptr (mod 2**(AW+1)); pointers wrap naturally.
//  FWFT: the head word is on the output combinationally from the array at rd_ptr. A pop at edge N
//   presents the next word after edge N. The host asserts rd one word early, so this is latency-correct.
//  Write into an empty FIFO at edge N: the word is visible and empty=0 after edge N (1-cycle fall-through).
//  Push when full and no pop: word dropped, pointers unchanged.
//  Pop when empty: ignored; the output holds the last array value.
//  Simultaneous push+pop:
//   - not empty and not full: both occur, level unchanged.
//   - full: the pop frees a slot, so both occur.
//   - empty: the push occurs, the pop is ignored.
//  flush=1: both FIFOs' pointers go to 0 at the next edge, overriding any same-cycle push/pop.
//   Sticky flags are also cleared.
//  Mid-operation reset: all state lost immediately; no partial word is retained.
//  No FSM beyond the pointer logic; all outputs except the head words are registered or decoded from registers.
// CONFIGURATION
//  SD_FIFO_ERR_FLAGS_EN defined:
//   - tx_underrun set on host_rd && tx_empty; rx_overflow set on host_we && rx_full && !rx_rd.
//   - Both hold until flush or reset.
//  Not defined: tx_underrun and rx_overflow tied 0; no flag registers synthesized.
// STRUCTURE
//  Package sd_data_pkg: SD_DW=32, SD_FIFO_AW=4 defaults, and the level type width SD_FIFO_AW+1.
//  Sub-module sd_fifo_sync (DW, AW): one FWFT FIFO with push/pop/flush/full/empty/level.
//   Instantiated twice (TX, RX). The bridge adds only the port mapping and the sticky flags.
// TESTING
//  1 Reset with tx_wr=1 held -> all levels 0, empty=1, flags 0; first push after release gives tx_level=1.
//  2 Push 16 words 0x1000..0x100F, then a 17th 0xDEAD -> tx_full=1, tx_level=16, 0xDEAD dropped;
//    16 host_rd pops return 0x1000..0x100F in order, then tx_empty=1.
//  3 RX full (16), host_we and rx_rd same cycle -> rx_level stays 16, no overflow flag,
//    new word emerges 16th after current head.
//  4 TX empty, host_rd=1 -> level stays 0; tx_underrun=1 with macro, 0 without;
//    flush clears the flag next cycle.
//  5 TX level 7, flush with simultaneous tx_wr -> tx_level=0, tx_empty=1 next cycle.
//  6 Pointer wrap: 40 interleaved push/pop pairs with an incrementing pattern -> data order preserved,
//    level never exceeds 2.

Source files
------------

// File: rtl/sd_data_pkg.sv
// sd_data_pkg: shared widths and level type for the SD data FIFO bridge.
package sd_data_pkg;
  localparam int SD_DW = 32;
  localparam int SD_FIFO_AW = 4;
  localparam int SD_LVL_W = SD_FIFO_AW + 1;
  typedef logic [SD_LVL_W-1:0] sd_level_t;
endpackage

// File: rtl/sd_fifo_sync.sv
// sd_fifo_sync: single-clock first-word-fall-through FIFO with flush and level.
module sd_fifo_sync #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;
  assign empty_o = wr_ptr_q == rd_ptr_q;
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  always_comb begin
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // Array is reset so the head outputs read 0 after reset and no stale word survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end
endmodule

// File: rtl/sd_data_fifo_bridge.sv
// sd_data_fifo_bridge: TX/RX word FIFOs between bus and SD data serial host.
// Optional sticky error flags enabled by defining SD_FIFO_ERR_FLAGS_EN.
module sd_data_fifo_bridge
  import sd_data_pkg::*;
#(
  parameter int DW = SD_DW,
  parameter int AW = SD_FIFO_AW
) (
  input  logic          sd_clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          tx_wr,
  input  logic [DW-1:0] tx_wdata,
  output logic          tx_full,
  output logic [AW:0]   tx_level,
  input  logic          host_rd,
  output logic [DW-1:0] host_data_in,
  output logic          tx_empty,
  input  logic          host_we,
  input  logic [DW-1:0] host_data_out,
  input  logic          rx_rd,
  output logic [DW-1:0] rx_rdata,
  output logic          rx_empty,
  output logic          rx_full,
  output logic [AW:0]   rx_level,
  output logic          tx_underrun,
  output logic          rx_overflow
);
  sd_fifo_sync #(.DW(DW), .AW(AW)) u_tx (
    .clk(sd_clk), .rst_n(rst_n), .flush_i(flush),
    .push_i(tx_wr), .wdata_i(tx_wdata), .pop_i(host_rd),
    .rdata_o(host_data_in), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
  );
  sd_fifo_sync #(.DW(DW), .AW(AW)) u_rx (
    .clk(sd_clk), .rst_n(rst_n), .flush_i(flush),
    .push_i(host_we), .wdata_i(host_data_out), .pop_i(rx_rd),
    .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
  );
`ifdef SD_FIFO_ERR_FLAGS_EN
  logic underrun_q, underrun_d, overflow_q, overflow_d;
  always_comb begin
    underrun_d = flush ? 1'b0 : underrun_q || (host_rd && tx_empty);
    overflow_d = flush ? 1'b0 : overflow_q || (host_we && rx_full && !rx_rd);
  end
  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end
  assign tx_underrun = underrun_q;
  assign rx_overflow = overflow_q;
`else
  assign tx_underrun = 1'b0;
  assign rx_overflow = 1'b0;
`endif
endmodule
